// File: rtl/ma_rw_stage.sv
// +--------------------------------------------------------------------------+
// | ma_rw_stage : EX/MA latch, word-addressed data memory, MA/RW latch       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ma_rw_stage #(
  parameter int          DMEM_WORDS = 1024,
  parameter int          DMEM_AW    = 10,
  parameter int          CB_ST      = 0,
  parameter int          CB_LD      = 1,
  parameter int          CB_WB      = 6,
  parameter int          CB_CALL    = 8,
  parameter logic [3:0]  RA_REG     = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] output_EX_PC,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] EX_op2,
  input  logic [31:0] output_EX_IR,
  input  logic [21:0] output_EX_controlBus,
  input  logic        EX_valid,
  output logic        ma_valid,
  output logic        ma_is_load,
  output logic        ma_wb_en,
  output logic [3:0]  ma_rd,
  output logic [31:0] ma_fwd_data,
  output logic        wb_en,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] rw_PC,
  output logic [31:0] rw_IR
);

  // EX/MA latch
  logic        r_ma_valid;
  logic [31:0] r_ma_pc;
  logic [31:0] r_ma_alu;
  logic [31:0] r_ma_op2;
  logic [31:0] r_ma_ir;
  logic [21:0] r_ma_cb;

  // MA/RW latch
  logic        r_rw_valid;
  logic        r_rw_wb_en;
  logic [3:0]  r_rw_rd;
  logic [31:0] r_rw_data;
  logic [31:0] r_rw_pc;
  logic [31:0] r_rw_ir;

  logic [31:0] r_mem [DMEM_WORDS];

  logic               w_is_st;
  logic               w_is_ld;
  logic               w_is_wb;
  logic               w_is_call;
  logic [3:0]         w_src_reg;
  logic [3:0]         w_ma_rd;
  logic [DMEM_AW-1:0] w_addr;
  logic [31:0]        w_ld_data;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_fwd_data;
  logic [31:0]        w_rw_data;
  logic               w_st_fwd;
  logic [31:0]        w_st_data;
  logic               w_st_en;
  logic               w_unused_cb;

  assign w_is_st    = r_ma_cb[CB_ST];
  assign w_is_ld    = r_ma_cb[CB_LD];
  assign w_is_wb    = r_ma_cb[CB_WB];
  assign w_is_call  = r_ma_cb[CB_CALL];
  assign w_src_reg  = r_ma_ir[25:22];
  assign w_ma_rd    = w_is_call ? RA_REG : w_src_reg;
  assign w_addr     = r_ma_alu[DMEM_AW+1:2];
  assign w_ld_data  = r_mem[w_addr];
  assign w_pc_plus4 = r_ma_pc + 32'd4;
  assign w_fwd_data = w_is_call ? w_pc_plus4 : r_ma_alu;
  assign w_rw_data  = w_is_call ? w_pc_plus4 : (w_is_ld ? w_ld_data : r_ma_alu);

  // The instruction in RW has not reached the register file yet, so a store
  // reading the same register must take the value straight from the latch.
  assign w_st_fwd   = r_rw_wb_en && (r_rw_rd == w_src_reg);
  assign w_st_data  = w_st_fwd ? r_rw_data : r_ma_op2;
  assign w_st_en    = reset && r_ma_valid && w_is_st;

  assign w_unused_cb = ^r_ma_cb;

  always_ff @(posedge clk) begin
    if (w_st_en) begin
      r_mem[w_addr] <= w_st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ma_valid <= 1'b0;
      r_ma_pc    <= '0;
      r_ma_alu   <= '0;
      r_ma_op2   <= '0;
      r_ma_ir    <= '0;
      r_ma_cb    <= '0;
      r_rw_valid <= 1'b0;
      r_rw_wb_en <= 1'b0;
      r_rw_rd    <= '0;
      r_rw_data  <= '0;
      r_rw_pc    <= '0;
      r_rw_ir    <= '0;
    end else begin
      r_ma_valid <= EX_valid;
      r_ma_pc    <= output_EX_PC;
      r_ma_alu   <= ALU_Result;
      r_ma_op2   <= EX_op2;
      r_ma_ir    <= output_EX_IR;
      r_ma_cb    <= output_EX_controlBus;
      r_rw_valid <= r_ma_valid;
      r_rw_wb_en <= r_ma_valid && w_is_wb;
      r_rw_rd    <= w_ma_rd;
      r_rw_data  <= w_rw_data;
      r_rw_pc    <= r_ma_pc;
      r_rw_ir    <= r_ma_ir;
    end
  end

  assign ma_valid    = r_ma_valid;
  assign ma_is_load  = r_ma_valid && w_is_ld;
  assign ma_wb_en    = r_ma_valid && w_is_wb;
  assign ma_rd       = w_ma_rd;
  assign ma_fwd_data = w_fwd_data;
  assign wb_en       = r_rw_wb_en;
  assign wb_rd       = r_rw_rd;
  assign wb_data     = r_rw_data;
  assign rw_PC       = r_rw_pc;
  assign rw_IR       = r_rw_ir;

endmodule

`default_nettype wire

// File: tb/tb_ma_rw_stage.sv
// +--------------------------------------------------------------------------+
// | tb_ma_rw_stage : directed bench with an instruction-level reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ma_rw_stage;

  localparam int         WORDS = 1024;
  localparam logic [21:0] C_ST   = 22'h001;
  localparam logic [21:0] C_LD   = 22'h002;
  localparam logic [21:0] C_WB   = 22'h040;
  localparam logic [21:0] C_CALL = 22'h100;

  logic        clk;
  logic        reset;
  logic [31:0] ex_pc, ex_alu, ex_op2, ex_ir;
  logic [21:0] ex_cb;
  logic        ex_valid;
  logic        ma_valid, ma_is_load, ma_wb_en, wb_en;
  logic [3:0]  ma_rd, wb_rd;
  logic [31:0] ma_fwd_data, wb_data, rw_PC, rw_IR;

  int n_tests = 0;
  int n_fail  = 0;

  ma_rw_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .output_EX_PC         (ex_pc),
    .ALU_Result           (ex_alu),
    .EX_op2               (ex_op2),
    .output_EX_IR         (ex_ir),
    .output_EX_controlBus (ex_cb),
    .EX_valid             (ex_valid),
    .ma_valid             (ma_valid),
    .ma_is_load           (ma_is_load),
    .ma_wb_en             (ma_wb_en),
    .ma_rd                (ma_rd),
    .ma_fwd_data          (ma_fwd_data),
    .wb_en                (wb_en),
    .wb_rd                (wb_rd),
    .wb_data              (wb_data),
    .rw_PC                (rw_PC),
    .rw_IR                (rw_IR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per pipeline slot, memory as a plain array
  typedef struct {
    logic        v;
    logic [31:0] pc, alu, op2, ir;
    logic [21:0] cb;
  } ex_t;

  typedef struct {
    logic        v, wb, known;
    logic [3:0]  rd;
    logic [31:0] data, pc, ir;
  } rw_t;

  ex_t         m_ma;
  rw_t         m_rw, m_nx;
  logic [31:0] m_mem [WORDS];
  bit          m_known [WORDS];
  bit          started = 0;
  int          m_w;
  bit          m_fwd;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      m_ma = '{v: 1'b0, pc: '0, alu: '0, op2: '0, ir: '0, cb: '0};
      m_rw = '{v: 1'b0, wb: 1'b0, known: 1'b1, rd: '0, data: '0, pc: '0, ir: '0};
    end else begin
      m_w        = int'((m_ma.alu / 32'd4) % WORDS);
      m_nx.v     = m_ma.v;
      m_nx.wb    = m_ma.v && (m_ma.cb & C_WB) != 0;
      m_nx.rd    = ((m_ma.cb & C_CALL) != 0) ? 4'd15 : m_ma.ir[25:22];
      m_nx.pc    = m_ma.pc;
      m_nx.ir    = m_ma.ir;
      m_nx.known = 1'b1;
      if ((m_ma.cb & C_CALL) != 0)     m_nx.data = m_ma.pc + 32'd4;
      else if ((m_ma.cb & C_LD) != 0) begin
        m_nx.data  = m_mem[m_w];
        m_nx.known = m_known[m_w];
      end else                         m_nx.data = m_ma.alu;
      if (m_ma.v && (m_ma.cb & C_ST) != 0) begin
        m_fwd = m_rw.wb && (m_rw.rd == m_ma.ir[25:22]);
        m_mem[m_w]   = m_fwd ? m_rw.data : m_ma.op2;
        m_known[m_w] = m_fwd ? m_rw.known : 1'b1;
      end
      m_rw = m_nx;
      m_ma = '{v: ex_valid, pc: ex_pc, alu: ex_alu, op2: ex_op2, ir: ex_ir, cb: ex_cb};
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ma_valid",    {31'd0, ma_valid},   {31'd0, m_ma.v});
      chk("ma_is_load",  {31'd0, ma_is_load}, {31'd0, m_ma.v && (m_ma.cb & C_LD) != 0});
      chk("ma_wb_en",    {31'd0, ma_wb_en},   {31'd0, m_ma.v && (m_ma.cb & C_WB) != 0});
      chk("ma_rd",       {28'd0, ma_rd},
          {28'd0, ((m_ma.cb & C_CALL) != 0) ? 4'd15 : m_ma.ir[25:22]});
      chk("ma_fwd_data", ma_fwd_data,
          ((m_ma.cb & C_CALL) != 0) ? m_ma.pc + 32'd4 : m_ma.alu);
      chk("wb_en",       {31'd0, wb_en},      {31'd0, m_rw.wb});
      chk("wb_rd",       {28'd0, wb_rd},      {28'd0, m_rw.rd});
      if (m_rw.known) chk("wb_data", wb_data, m_rw.data);
      chk("rw_PC",       rw_PC,               m_rw.pc);
      chk("rw_IR",       rw_IR,               m_rw.ir);
    end
  end

  function automatic logic [31:0] ird(input logic [3:0] rd);
    return {6'd0, rd, 22'd0};
  endfunction

  task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] op2, input logic [31:0] ir, input logic [21:0] cb);
    ex_valid = v;
    ex_pc    = pc;
    ex_alu   = alu;
    ex_op2   = op2;
    ex_ir    = ir;
    ex_cb    = cb;
    @(negedge clk);
  endtask

  task automatic bubble();
    issue(1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    reset = 1'b0;
    ex_valid = 1'b0; ex_pc = '0; ex_alu = '0; ex_op2 = '0; ex_ir = '0; ex_cb = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Seed word 4, then reset while a store to 0x10 is in flight and presented
    issue(1'b1, 32'h200, 32'h10, 32'hA5A50001, ird(4'd5), C_ST);
    bubble();
    issue(1'b1, 32'h204, 32'h10, 32'h0BAD0BAD, ird(4'd5), C_ST);
    reset = 1'b0;
    issue(1'b1, 32'h204, 32'h10, 32'h0BAD0BAD, ird(4'd5), C_ST);
    issue(1'b1, 32'h204, 32'h10, 32'h0BAD0BAD, ird(4'd5), C_ST);
    chk("rst_ma_valid",    {31'd0, ma_valid}, 32'd0);
    chk("rst_wb_en",       {31'd0, wb_en},    32'd0);
    chk("rst_wb_data",     wb_data,           32'd0);
    chk("rst_rw_PC",       rw_PC,             32'd0);
    chk("rst_ma_fwd_data", ma_fwd_data,       32'd0);
    reset = 1'b1;
    bubble();
    issue(1'b1, 32'h208, 32'h10, 32'h0, ird(4'd2), C_LD | C_WB);
    bubble();
    chk("rst_mem_kept", wb_data, 32'hA5A50001);

    // Store then load of the same address on back-to-back cycles
    issue(1'b1, 32'h300, 32'h40, 32'hDEADBEEF, ird(4'd7), C_ST);
    issue(1'b1, 32'h304, 32'h40, 32'h0, ird(4'd3), C_LD | C_WB);
    bubble();
    chk("ld_wb_en",   {31'd0, wb_en}, 32'd1);
    chk("ld_wb_rd",   {28'd0, wb_rd}, 32'd3);
    chk("ld_wb_data", wb_data,        32'hDEADBEEF);

    // Call writes the return address into r15
    issue(1'b1, 32'h100, 32'h0, 32'h0, ird(4'd2), C_CALL | C_WB);
    chk("call_ma_fwd", ma_fwd_data,     32'h104);
    chk("call_ma_rd",  {28'd0, ma_rd},  32'd15);
    bubble();
    chk("call_wb_rd",   {28'd0, wb_rd}, 32'd15);
    chk("call_wb_data", wb_data,        32'h104);

    // Load r1 followed immediately by a store of r1 with stale op2
    issue(1'b1, 32'h400, 32'h60, 32'h55, ird(4'd9), C_ST);
    bubble();
    issue(1'b1, 32'h408, 32'h60, 32'h0, ird(4'd1), C_LD | C_WB);
    issue(1'b1, 32'h40C, 32'h80, 32'h0, ird(4'd1), C_ST);
    chk("fwd_src_rd",   {28'd0, wb_rd}, 32'd1);
    chk("fwd_src_data", wb_data,        32'h55);
    bubble();
    issue(1'b1, 32'h410, 32'h80, 32'h0, ird(4'd4), C_LD | C_WB);
    bubble();
    chk("fwd_mem_data", wb_data, 32'h55);

    // Address wrap, and a bubble carrying store bits that must not write
    issue(1'b1, 32'h500, 32'h1008, 32'h12345678, ird(4'd6), C_ST);
    issue(1'b0, 32'h504, 32'h8, 32'hFFFFFFFF, ird(4'd6), C_ST);
    issue(1'b1, 32'h508, 32'h8, 32'h0, ird(4'd5), C_LD | C_WB);
    chk("bubble_wb_en", {31'd0, wb_en}, 32'd0);
    bubble();
    chk("wrap_wb_rd",   {28'd0, wb_rd}, 32'd5);
    chk("wrap_wb_data", wb_data,        32'h12345678);

    repeat (3) bubble();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end of the directed sequence");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
